// File: rtl/bg_affine_pixel_fetch.sv
// Affine BG pixel fetcher: turns one texture coordinate into a palette index
// through two dependent VRAM byte reads (map entry, then 8bpp tile texel).
module bg_affine_pixel_fetch #(
  parameter int unsigned ADDR_W = 17
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic              overflow,
  input  logic [1:0]        map_size,
  input  logic              wrap,
  input  logic [4:0]        screen_base,
  input  logic [1:0]        char_base,
  input  logic              abort,
  output logic              vram_req,
  output logic [ADDR_W-1:0] vram_addr,
  input  logic              vram_ack,
  input  logic [15:0]       vram_rdata,
  output logic              busy,
  output logic              pixel_valid,
  output logic [7:0]        palette_idx,
  output logic              transparent
);

  localparam int unsigned COORD_W = 10;
  localparam int unsigned SPAN_W  = 11;
  localparam int unsigned VA_W    = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_MAP_RD,
    ST_TILE_RD,
    ST_DONE
  } state_e;

  state_e             state_q, state_d;
  logic               req_q, req_d;
  logic [VA_W-1:0]    addr_q, addr_d;
  logic               busy_q, busy_d;
  logic               pv_q, pv_d;
  logic [7:0]         pal_q, pal_d;
  logic               transp_q, transp_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic               ovf_q, ovf_d;
  logic [1:0]         size_q, size_d;
  logic               wrap_q, wrap_d;
  logic [4:0]         sbase_q, sbase_d;
  logic [1:0]         cbase_q, cbase_d;

  logic [SPAN_W-1:0]  span;
  logic [COORD_W-1:0] mask, xm, ym;
  logic               outside;
  logic [VA_W-1:0]    map_addr, tile_addr;
  logic [7:0]         rd_byte;

  // Map side length is a power of two dividing 1024, so masking is the wrap modulus
  always_comb begin
    span      = SPAN_W'(11'd128) << size_q;
    outside   = ovf_q | ({1'b0, x_q} >= span) | ({1'b0, y_q} >= span);
    mask      = COORD_W'(span - SPAN_W'(1));
    xm        = x_q & mask;
    ym        = y_q & mask;
    rd_byte   = addr_q[0] ? vram_rdata[15:8] : vram_rdata[7:0];
    map_addr  = {sbase_q, 11'b0}
              + (VA_W'(ym[9:3]) << (3'd4 + {1'b0, size_q}))
              + VA_W'(xm[9:3]);
    tile_addr = {cbase_q, 14'b0} + {2'b0, rd_byte, 6'b0} + VA_W'({ym[2:0], xm[2:0]});
  end

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    addr_d   = addr_q;
    busy_d   = busy_q;
    pv_d     = 1'b0;
    pal_d    = pal_q;
    transp_d = transp_q;
    x_d      = x_q;
    y_d      = y_q;
    ovf_d    = ovf_q;
    size_d   = size_q;
    wrap_d   = wrap_q;
    sbase_d  = sbase_q;
    cbase_d  = cbase_q;

    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (outside && !wrap_q) begin
          state_d  = ST_DONE;
          pal_d    = 8'd0;
          transp_d = 1'b1;
          pv_d     = 1'b1;
        end else begin
          state_d = ST_MAP_RD;
          req_d   = 1'b1;
          addr_d  = map_addr;
        end
      end
      ST_MAP_RD: begin
        if (vram_ack) begin
          state_d = ST_TILE_RD;
          addr_d  = tile_addr;
        end
      end
      ST_TILE_RD: begin
        if (vram_ack) begin
          state_d  = ST_DONE;
          req_d    = 1'b0;
          pal_d    = rd_byte;
          transp_d = (rd_byte == 8'd0);
          pv_d     = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = start ? ST_CHECK : ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
    endcase

    // Request capture happens only in states that can accept a new start
    if (start && (state_q == ST_IDLE || state_q == ST_DONE)) begin
      x_d     = x;
      y_d     = y;
      ovf_d   = overflow;
      size_d  = map_size;
      wrap_d  = wrap;
      sbase_d = screen_base;
      cbase_d = char_base;
    end

    busy_d = (state_d != ST_IDLE);

    // Abort overrides everything, including an ack or start in the same cycle
    if (abort) begin
      state_d  = ST_IDLE;
      req_d    = 1'b0;
      busy_d   = 1'b0;
      pv_d     = 1'b0;
      pal_d    = pal_q;
      transp_d = transp_q;
      x_d      = x_q;
      y_d      = y_q;
      ovf_d    = ovf_q;
      size_d   = size_q;
      wrap_d   = wrap_q;
      sbase_d  = sbase_q;
      cbase_d  = cbase_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      req_q    <= 1'b0;
      addr_q   <= '0;
      busy_q   <= 1'b0;
      pv_q     <= 1'b0;
      pal_q    <= 8'd0;
      transp_q <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      ovf_q    <= 1'b0;
      size_q   <= 2'd0;
      wrap_q   <= 1'b0;
      sbase_q  <= 5'd0;
      cbase_q  <= 2'd0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      busy_q   <= busy_d;
      pv_q     <= pv_d;
      pal_q    <= pal_d;
      transp_q <= transp_d;
      x_q      <= x_d;
      y_q      <= y_d;
      ovf_q    <= ovf_d;
      size_q   <= size_d;
      wrap_q   <= wrap_d;
      sbase_q  <= sbase_d;
      cbase_q  <= cbase_d;
    end
  end

  assign vram_req    = req_q;
  assign vram_addr   = ADDR_W'(addr_q);
  assign busy        = busy_q;
  assign pixel_valid = pv_q;
  assign palette_idx = pal_q;
  assign transparent = transp_q;

endmodule

// File: tb/tb_bg_affine_pixel_fetch.sv
// Bench for bg_affine_pixel_fetch: byte-array VRAM with a wait-state responder and
// an arithmetic reference model of the map/tile lookup.
module tb_bg_affine_pixel_fetch;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [9:0]  x, y;
  logic        overflow;
  logic [1:0]  map_size;
  logic        wrap;
  logic [4:0]  screen_base;
  logic [1:0]  char_base;
  logic        abort;
  logic        vram_req;
  logic [16:0] vram_addr;
  logic        vram_ack;
  logic [15:0] vram_rdata;
  logic        busy;
  logic        pixel_valid;
  logic [7:0]  palette_idx;
  logic        transparent;

  logic [7:0]  mem [0:65535];
  logic [16:0] rd_log [$];
  int          wait_target = 0;
  int          req_cycles  = 0;
  int          stab_err    = 0;
  int          n_tests     = 0;
  int          n_fail      = 0;

  always #5 clock = ~clock;

  bg_affine_pixel_fetch #(.ADDR_W(17)) dut (
    .clock(clock), .reset(reset), .start(start), .x(x), .y(y), .overflow(overflow),
    .map_size(map_size), .wrap(wrap), .screen_base(screen_base), .char_base(char_base),
    .abort(abort), .vram_req(vram_req), .vram_addr(vram_addr), .vram_ack(vram_ack),
    .vram_rdata(vram_rdata), .busy(busy), .pixel_valid(pixel_valid),
    .palette_idx(palette_idx), .transparent(transparent)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // VRAM responder: acks after wait_target stalled cycles, logs acked addresses
  initial begin
    int          wait_cnt;
    bit          pend;
    logic [16:0] pend_addr;
    logic [15:0] a;
    wait_cnt   = 0;
    pend       = 1'b0;
    pend_addr  = '0;
    vram_ack   = 1'b0;
    vram_rdata = 16'd0;
    forever begin
      @(negedge clock);
      vram_ack   = 1'b0;
      vram_rdata = 16'($urandom);
      if (vram_req) begin
        req_cycles++;
        if (pend && vram_addr !== pend_addr) stab_err++;
        if (wait_cnt >= wait_target) begin
          a          = vram_addr[15:0] & 16'hFFFE;
          vram_ack   = 1'b1;
          vram_rdata = {mem[a | 16'd1], mem[a]};
          rd_log.push_back(vram_addr);
          wait_cnt   = 0;
          pend       = 1'b0;
        end else begin
          wait_cnt++;
          pend      = 1'b1;
          pend_addr = vram_addr;
        end
      end else begin
        wait_cnt = 0;
        pend     = 1'b0;
      end
    end
  end

  task automatic drive_req(input int xi, input int yi, input int ov, input int sz,
                           input int wr, input int sb, input int cb);
    x           = 10'(xi);
    y           = 10'(yi);
    overflow    = 1'(ov);
    map_size    = 2'(sz);
    wrap        = 1'(wr);
    screen_base = 5'(sb);
    char_base   = 2'(cb);
  endtask

  // One request; called right after a falling edge with the DUT idle
  task automatic do_txn(input int xi, input int yi, input int ov, input int sz, input int wr,
                        input int sb, input int cb, input int w, input bit mid_i);
    int s, xm, ym, maddr, tile, taddr, px, exp_lat, exp_reads;
    int base, rq0, st0, lat, pv_count, busy_bad, n_rd;
    bit got, mid;
    logic [7:0] pal;
    logic       tr;
    xm = 0; ym = 0; maddr = 0; taddr = 0;
    s = 128 << sz;
    if ((ov != 0 || xi >= s || yi >= s) && wr == 0) begin
      exp_lat = 2; exp_reads = 0; px = 0;
    end else begin
      xm      = xi % s;
      ym      = yi % s;
      maddr   = (sb * 2048 + (ym / 8) * (s / 8) + xm / 8) % 65536;
      tile    = int'(mem[maddr]);
      taddr   = cb * 16384 + tile * 64 + (ym % 8) * 8 + xm % 8;
      px      = int'(mem[taddr]);
      exp_lat = 4 + 2 * w;
      exp_reads = 2;
    end
    mid = mid_i && exp_reads == 2;
    wait_target = w;
    base = rd_log.size(); rq0 = req_cycles; st0 = stab_err;
    got = 1'b0; lat = 0; pv_count = 0; busy_bad = 0; pal = 8'd0; tr = 1'b0;
    drive_req(xi, yi, ov, sz, wr, sb, cb);
    start = 1'b1;
    for (int c = 1; c <= exp_lat + 6; c++) begin
      @(negedge clock);
      start = 1'b0;
      if (mid && c == 3) begin
        drive_req(int'($urandom_range(1023)), int'($urandom_range(1023)), 0,
                  int'($urandom_range(3)), 1, int'($urandom_range(31)), int'($urandom_range(3)));
        start = 1'b1;
      end
      if (pixel_valid) begin
        pv_count++;
        if (!got) begin
          got = 1'b1; lat = c; pal = palette_idx; tr = transparent;
        end
      end else if (!got && !busy) busy_bad++;
    end
    start = 1'b0;
    if (!got) chk("pv_timeout", 32'd0, 32'd1);
    chk("latency", lat, exp_lat);
    chk("pv_count", pv_count, 1);
    chk("palette", {24'd0, pal}, px);
    chk("transparent", {31'd0, tr}, (px == 0) ? 1 : 0);
    n_rd = rd_log.size() - base;
    chk("reads", n_rd, exp_reads);
    if (n_rd >= 2 && exp_reads == 2) begin
      chk("map_addr", {15'd0, rd_log[base]}, maddr);
      chk("tile_addr", {15'd0, rd_log[base + 1]}, taddr);
    end
    chk("req_cycles", req_cycles - rq0, (exp_reads == 0) ? 0 : 2 + 2 * w);
    chk("busy_held", busy_bad, 0);
    chk("addr_stable", stab_err - st0, 0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_req"},   {31'd0, vram_req}, 0);
    chk({tag, "_addr"},  {15'd0, vram_addr}, 0);
    chk({tag, "_busy"},  {31'd0, busy}, 0);
    chk({tag, "_pv"},    {31'd0, pixel_valid}, 0);
    chk({tag, "_pal"},   {24'd0, palette_idx}, 0);
    chk({tag, "_transp"}, {31'd0, transparent}, 0);
  endtask

  initial begin
    int pv_seen;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    drive_req(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clock);
    chk_zero_outputs("reset");
    reset = 1'b0;
    @(negedge clock);

    // Basic fetch, even map address
    mem[16'h0812] = 8'h03; mem[16'h00CC] = 8'h45;
    do_txn(20, 9, 0, 0, 0, 1, 0, 0, 1'b0);
    // Out of area, transparent outside
    do_txn(130, 5, 0, 0, 0, 1, 0, 0, 1'b0);
    do_txn(3, 5, 1, 0, 0, 1, 0, 0, 1'b0);
    // Wrapping, even and odd map byte
    mem[16'h0800] = 8'h10; mem[16'h0801] = 8'h22;
    mem[16'h042A] = 8'h77; mem[16'h08A8] = 8'h99;
    do_txn(130, 5, 0, 0, 1, 1, 0, 0, 1'b0);
    do_txn(8, 5, 0, 0, 0, 1, 0, 0, 1'b0);
    do_txn(3, 5, 1, 0, 1, 1, 0, 1, 1'b0);
    // Stalled acks with an ignored mid-fetch start
    do_txn(20, 9, 0, 0, 0, 1, 0, 3, 1'b1);
    // Zero texel
    mem[16'h00CC] = 8'h00;
    do_txn(20, 9, 0, 0, 0, 1, 0, 0, 1'b0);
    mem[16'h00CC] = 8'h45;

    // Abort coinciding with the tile ack
    wait_target = 0;
    drive_req(20, 9, 0, 0, 0, 1, 0);
    start = 1'b1;
    @(negedge clock); start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    abort = 1'b1;
    chk("abort_req", {31'd0, vram_req}, 1);
    chk("abort_addr", {15'd0, vram_addr}, 32'h0CC);
    @(negedge clock);
    abort = 1'b0;
    chk("abort_pv", {31'd0, pixel_valid}, 0);
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_req_low", {31'd0, vram_req}, 0);
    do_txn(20, 9, 0, 0, 0, 1, 0, 0, 1'b0);

    // Abort beats a start in idle
    start = 1'b1; abort = 1'b1;
    @(negedge clock);
    start = 1'b0; abort = 1'b0;
    chk("abort_start_busy", {31'd0, busy}, 0);
    @(negedge clock);
    chk("abort_start_pv", {31'd0, pixel_valid}, 0);

    // Reset while the map read is stalled
    wait_target = 2;
    drive_req(20, 9, 0, 0, 0, 1, 0);
    start = 1'b1;
    @(negedge clock); start = 1'b0;
    @(negedge clock);
    chk("rst_mid_req", {31'd0, vram_req}, 1);
    #1 reset = 1'b1;
    #1 chk_zero_outputs("rst_mid");
    @(negedge clock);
    reset = 1'b0;
    pv_seen = 0;
    repeat (8) begin
      @(negedge clock);
      if (pixel_valid) pv_seen++;
    end
    chk("rst_mid_no_pv", pv_seen, 0);
    do_txn(20, 9, 0, 0, 0, 1, 0, 1, 1'b0);

    // Randomized requests against the model
    for (int i = 0; i < 200; i++) begin
      do_txn(int'($urandom_range(1023)), int'($urandom_range(1023)),
             ($urandom_range(7) == 0) ? 1 : 0, int'($urandom_range(3)),
             int'($urandom_range(1)), int'($urandom_range(31)), int'($urandom_range(3)),
             int'($urandom_range(2)), ($urandom_range(3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
